// File: rtl/voice_allocator.sv
// voice_allocator: polyphonic voice allocator between the MIDI decoder and the
// synthesis pipelines. Channel-filtered note-on/note-off/all-notes-off events
// are assigned to VOICE_COUNT slots. When no slot is free, the oldest voice is
// stolen.
//
// Optional feature macro: SUSTAIN_PEDAL_EN (CC64 per-channel sustain with
// per-voice held bits). When it is undefined, CC64 is ignored.
//
// Handshake: a message is taken on a clock edge where msg_valid && msg_ready.
// msg_ready is high only in IDLE. A msg_valid seen while msg_ready is low is
// dropped, not queued. Each accepted message walks IDLE -> SEARCH -> COMMIT.
module voice_allocator #(
  parameter int          VOICE_COUNT  = 8,
  parameter logic [15:0] CHANNEL_MASK = 16'hFFFF,
  localparam int         RANK_WIDTH   = $clog2(VOICE_COUNT),
  localparam int         COUNT_WIDTH  = $clog2(VOICE_COUNT + 1)
) (
  input  logic                          clock_50_000_000,
  input  logic                          reset,
  input  logic [7:0]                    msg_status,
  input  logic [7:0]                    msg_data1,
  input  logic [7:0]                    msg_data2,
  input  logic                          msg_valid,
  output logic                          msg_ready,
  output logic [VOICE_COUNT-1:0][6:0]   voice_note,
  output logic [VOICE_COUNT-1:0][6:0]   voice_velocity,
  output logic [VOICE_COUNT-1:0]        voice_gate,
  output logic [VOICE_COUNT-1:0]        voice_update,
  output logic                          voice_stolen,
  output logic [COUNT_WIDTH-1:0]        active_count
);

  typedef enum logic [1:0] {IDLE, SEARCH, COMMIT} state_t;

  state_t state, state_next;

  // Latched message
  logic [3:0] lat_type, lat_chan;
  logic [7:0] lat_d1, lat_d2;

  // Per-voice bookkeeping not visible on the ports
  logic [VOICE_COUNT-1:0][3:0]            voice_chan;
  logic [VOICE_COUNT-1:0][RANK_WIDTH-1:0] rank;

  // SEARCH results
  logic [VOICE_COUNT-1:0] match_vec, free_vec, match_c;
  logic [RANK_WIDTH-1:0]  oldest, oldest_c;

  // COMMIT next values
  logic [VOICE_COUNT-1:0][6:0]            note_n, vel_n;
  logic [VOICE_COUNT-1:0][3:0]            chan_n;
  logic [VOICE_COUNT-1:0][RANK_WIDTH-1:0] rank_n;
  logic [VOICE_COUNT-1:0]                 gate_n, upd_n;
  logic                                   stolen_n, steal;
  logic [RANK_WIDTH-1:0]                  tgt;
  logic [COUNT_WIDTH-1:0]                 count_n;

  logic chan_ok, is_on, is_off, is_anf;

`ifdef SUSTAIN_PEDAL_EN
  logic [15:0]            sustain, sustain_n;
  logic [VOICE_COUNT-1:0] held, held_n;
  logic                   is_sus;
  assign is_sus = (lat_type == 4'hB) && (lat_d1 == 8'd64);
`endif

  assign chan_ok = CHANNEL_MASK[lat_chan];
  assign is_on   = (lat_type == 4'h9) && (lat_d2 != 8'd0);
  assign is_off  = (lat_type == 4'h8) || ((lat_type == 4'h9) && (lat_d2 == 8'd0));
  assign is_anf  = (lat_type == 4'hB) && (lat_d1 == 8'd123);

  // FSM state register
  always_ff @(posedge clock_50_000_000 or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // FSM next state and ready
  always_comb begin
    state_next = state;
    msg_ready  = 1'b0;
    case (state)
      IDLE: begin
        msg_ready = 1'b1;
        if (msg_valid) state_next = SEARCH;
      end
      SEARCH:  state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Capture the message on acceptance
  always_ff @(posedge clock_50_000_000 or posedge reset) begin
    if (reset) begin
      lat_type <= '0;
      lat_chan <= '0;
      lat_d1   <= '0;
      lat_d2   <= '0;
    end else if (state == IDLE && msg_valid) begin
      lat_type <= msg_status[7:4];
      lat_chan <= msg_status[3:0];
      lat_d1   <= msg_data1;
      lat_d2   <= msg_data2;
    end
  end

  // Match vector and oldest voice from the current voice state
  always_comb begin
    match_c  = '0;
    oldest_c = '0;
    for (int v = 0; v < VOICE_COUNT; v++) begin
      match_c[v] = voice_gate[v] && (voice_chan[v] == lat_chan) &&
                   (voice_note[v] == lat_d1[6:0]);
      if (rank[v] == RANK_WIDTH'(VOICE_COUNT - 1)) oldest_c = RANK_WIDTH'(v);
    end
  end

  // Register SEARCH results
  always_ff @(posedge clock_50_000_000 or posedge reset) begin
    if (reset) begin
      match_vec <= '0;
      free_vec  <= '0;
      oldest    <= '0;
    end else if (state == SEARCH) begin
      match_vec <= match_c;
      free_vec  <= ~voice_gate;
      oldest    <= oldest_c;
    end
  end

  // Note-on target: lowest match, else lowest free voice, else the oldest voice
  always_comb begin
    tgt   = oldest;
    steal = 1'b1;
    for (int v = VOICE_COUNT - 1; v >= 0; v--) begin
      if (free_vec[v]) begin
        tgt   = RANK_WIDTH'(v);
        steal = 1'b0;
      end
    end
    for (int v = VOICE_COUNT - 1; v >= 0; v--) begin
      if (match_vec[v]) begin
        tgt   = RANK_WIDTH'(v);
        steal = 1'b0;
      end
    end
  end

  // Next voice state applied in COMMIT
  always_comb begin
    note_n   = voice_note;
    vel_n    = voice_velocity;
    gate_n   = voice_gate;
    chan_n   = voice_chan;
    rank_n   = rank;
    upd_n    = '0;
    stolen_n = 1'b0;
`ifdef SUSTAIN_PEDAL_EN
    held_n    = held;
    sustain_n = sustain;
`endif
    if (chan_ok) begin
      if (is_on) begin
        note_n[tgt] = lat_d1[6:0];
        vel_n[tgt]  = lat_d2[6:0];
        gate_n[tgt] = 1'b1;
        chan_n[tgt] = lat_chan;
        upd_n[tgt]  = 1'b1;
        stolen_n    = steal;
        // Voices younger than the target age by one; the target becomes youngest
        for (int v = 0; v < VOICE_COUNT; v++) begin
          if (rank[v] < rank[tgt]) rank_n[v] = rank[v] + RANK_WIDTH'(1);
        end
        rank_n[tgt] = '0;
`ifdef SUSTAIN_PEDAL_EN
        held_n[tgt] = 1'b0;
`endif
      end else if (is_off) begin
`ifdef SUSTAIN_PEDAL_EN
        if (sustain[lat_chan]) begin
          held_n = held | match_vec;
        end else begin
          gate_n = voice_gate & ~match_vec;
          held_n = held & ~match_vec;
          upd_n  = match_vec;
        end
`else
        gate_n = voice_gate & ~match_vec;
        upd_n  = match_vec;
`endif
      end else if (is_anf) begin
        for (int v = 0; v < VOICE_COUNT; v++) begin
          if (voice_gate[v] && voice_chan[v] == lat_chan) begin
            gate_n[v] = 1'b0;
            upd_n[v]  = 1'b1;
`ifdef SUSTAIN_PEDAL_EN
            held_n[v] = 1'b0;
`endif
          end
        end
      end
`ifdef SUSTAIN_PEDAL_EN
      else if (is_sus) begin
        sustain_n[lat_chan] = (lat_d2 >= 8'd64);
        if (lat_d2 < 8'd64) begin
          for (int v = 0; v < VOICE_COUNT; v++) begin
            if (held[v] && voice_chan[v] == lat_chan) begin
              gate_n[v] = 1'b0;
              held_n[v] = 1'b0;
              upd_n[v]  = 1'b1;
            end
          end
        end
      end
`endif
    end
  end

  // Popcount of the next gate vector
  always_comb begin
    count_n = '0;
    for (int v = 0; v < VOICE_COUNT; v++) count_n = count_n + COUNT_WIDTH'(gate_n[v]);
  end

  // Voice registers and one-cycle pulses
  always_ff @(posedge clock_50_000_000 or posedge reset) begin
    if (reset) begin
      voice_note     <= '0;
      voice_velocity <= '0;
      voice_gate     <= '0;
      voice_chan     <= '0;
      voice_update   <= '0;
      voice_stolen   <= 1'b0;
      active_count   <= '0;
      for (int v = 0; v < VOICE_COUNT; v++) rank[v] <= RANK_WIDTH'(v);
`ifdef SUSTAIN_PEDAL_EN
      held    <= '0;
      sustain <= '0;
`endif
    end else begin
      voice_update <= '0;
      voice_stolen <= 1'b0;
      if (state == COMMIT) begin
        voice_note     <= note_n;
        voice_velocity <= vel_n;
        voice_gate     <= gate_n;
        voice_chan     <= chan_n;
        rank           <= rank_n;
        voice_update   <= upd_n;
        voice_stolen   <= stolen_n;
        active_count   <= count_n;
`ifdef SUSTAIN_PEDAL_EN
        held    <= held_n;
        sustain <= sustain_n;
`endif
      end
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: directed scenarios followed by random MIDI traffic,
// compared against an age-ordered list model of the voice pool.
module tb_voice_allocator;

  localparam int          V       = 8;
  localparam logic [15:0] TB_MASK = 16'h0005;  // channels 0 and 2 accepted, 1 filtered

  logic                clock_50_000_000 = 1'b0;
  logic                reset = 1'b1;
  logic [7:0]          msg_status = '0, msg_data1 = '0, msg_data2 = '0;
  logic                msg_valid = 1'b0;
  logic                msg_ready;
  logic [V-1:0][6:0]   voice_note, voice_velocity;
  logic [V-1:0]        voice_gate, voice_update;
  logic                voice_stolen;
  logic [3:0]          active_count;

  voice_allocator #(.VOICE_COUNT(V), .CHANNEL_MASK(TB_MASK)) dut (
    .clock_50_000_000 (clock_50_000_000),
    .reset            (reset),
    .msg_status       (msg_status),
    .msg_data1        (msg_data1),
    .msg_data2        (msg_data2),
    .msg_valid        (msg_valid),
    .msg_ready        (msg_ready),
    .voice_note       (voice_note),
    .voice_velocity   (voice_velocity),
    .voice_gate       (voice_gate),
    .voice_update     (voice_update),
    .voice_stolen     (voice_stolen),
    .active_count     (active_count)
  );

  // Clock
  always #5 clock_50_000_000 = ~clock_50_000_000;

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: age_q[0] is the youngest voice, age_q[$] the oldest
  int   m_note[V], m_vel[V], m_chan[V];
  bit   m_gate[V], m_held[V];
  bit   m_sus[16];
  int   age_q[$];
  logic [15:0] mask_v = TB_MASK;

  logic [V-1:0] exp_q[$];
  logic         exp_stl;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    age_q.delete();
    for (int v = 0; v < V; v++) begin
      m_note[v] = 0; m_vel[v] = 0; m_chan[v] = 0; m_gate[v] = 0; m_held[v] = 0;
      age_q.push_back(v);
    end
    for (int c = 0; c < 16; c++) m_sus[c] = 0;
    exp_q.delete();
  endtask

  task automatic model_apply(input logic [7:0] st, input logic [7:0] d1, input logic [7:0] d2,
                             output logic [V-1:0] upd, output logic stl);
    int typ = int'(st[7:4]);
    int ch  = int'(st[3:0]);
    int tgt = -1;
    upd = '0;
    stl = 1'b0;
    if (!mask_v[ch]) return;
    if (typ == 9 && d2 != 0) begin
      for (int v = 0; v < V; v++)
        if (tgt < 0 && m_gate[v] && m_chan[v] == ch && m_note[v] == int'(d1[6:0])) tgt = v;
      for (int v = 0; v < V; v++)
        if (tgt < 0 && !m_gate[v]) tgt = v;
      if (tgt < 0) begin
        tgt = age_q[V-1];
        stl = 1'b1;
      end
      m_note[tgt] = int'(d1[6:0]);
      m_vel[tgt]  = int'(d2[6:0]);
      m_gate[tgt] = 1;
      m_held[tgt] = 0;
      m_chan[tgt] = ch;
      upd[tgt]    = 1'b1;
      for (int i = 0; i < age_q.size(); i++)
        if (age_q[i] == tgt) begin
          age_q.delete(i);
          break;
        end
      age_q.push_front(tgt);
    end else if (typ == 8 || typ == 9) begin
      for (int v = 0; v < V; v++) begin
        if (m_gate[v] && m_chan[v] == ch && m_note[v] == int'(d1[6:0])) begin
`ifdef SUSTAIN_PEDAL_EN
          if (m_sus[ch]) begin
            m_held[v] = 1;
          end else begin
            m_gate[v] = 0; m_held[v] = 0; upd[v] = 1'b1;
          end
`else
          m_gate[v] = 0; upd[v] = 1'b1;
`endif
        end
      end
    end else if (typ == 11 && d1 == 8'd123) begin
      for (int v = 0; v < V; v++)
        if (m_gate[v] && m_chan[v] == ch) begin
          m_gate[v] = 0; m_held[v] = 0; upd[v] = 1'b1;
        end
    end
`ifdef SUSTAIN_PEDAL_EN
    else if (typ == 11 && d1 == 8'd64) begin
      if (d2 >= 8'd64) m_sus[ch] = 1;
      else begin
        m_sus[ch] = 0;
        for (int v = 0; v < V; v++)
          if (m_held[v] && m_chan[v] == ch) begin
            m_gate[v] = 0; m_held[v] = 0; upd[v] = 1'b1;
          end
      end
    end
`endif
  endtask

  task automatic check_voices(input string tag);
    logic [V-1:0][6:0] en, ev;
    logic [V-1:0]      eg;
    int                cnt = 0;
    for (int v = 0; v < V; v++) begin
      en[v] = 7'(m_note[v]);
      ev[v] = 7'(m_vel[v]);
      eg[v] = m_gate[v];
      cnt  += int'(m_gate[v]);
    end
    check({tag, "/note"}, 64'(voice_note), 64'(en));
    check({tag, "/vel"},  64'(voice_velocity), 64'(ev));
    check({tag, "/gate"}, 64'(voice_gate), 64'(eg));
    check({tag, "/count"}, 64'(active_count), 64'(cnt));
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after commit
  task automatic send_msg(input string tag, input logic [7:0] st, input logic [7:0] d1,
                          input logic [7:0] d2);
    logic [V-1:0] eu;
    logic         es;
    check({tag, "/ready_idle"}, 64'(msg_ready), 64'd1);
    msg_status = st; msg_data1 = d1; msg_data2 = d2; msg_valid = 1'b1;
    @(posedge clock_50_000_000); #1;
    msg_valid = 1'b0;
    model_apply(st, d1, d2, eu, es);
    exp_q.push_back(eu);
    exp_stl = es;
    @(negedge clock_50_000_000);
    check({tag, "/ready_e1"}, 64'(msg_ready), 64'd0);
    @(negedge clock_50_000_000);
    check({tag, "/ready_e2"}, 64'(msg_ready), 64'd0);
    check({tag, "/upd_early"}, 64'(voice_update), 64'd0);
    @(negedge clock_50_000_000);
    check({tag, "/ready_back"}, 64'(msg_ready), 64'd1);
    check({tag, "/update"}, 64'(voice_update), 64'(exp_q.pop_front()));
    check({tag, "/stolen"}, 64'(voice_stolen), 64'(exp_stl));
    check_voices(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    msg_valid = 1'b0;
    repeat (2) @(negedge clock_50_000_000);
    reset = 1'b0;
    model_reset();
    @(negedge clock_50_000_000);
  endtask

  initial begin
    logic [V-1:0] eu;
    logic         es;
    model_reset();
    @(negedge clock_50_000_000);
    @(negedge clock_50_000_000);

    // Reset state (reset still asserted)
    check("rst/ready", 64'(msg_ready), 64'd1);
    check("rst/gate", 64'(voice_gate), 64'd0);
    check("rst/update", 64'(voice_update), 64'd0);
    check("rst/stolen", 64'(voice_stolen), 64'd0);
    check("rst/note", 64'(voice_note), 64'd0);
    check("rst/vel", 64'(voice_velocity), 64'd0);
    check("rst/count", 64'(active_count), 64'd0);
    do_reset();

    // Single note-on lands on voice 0
    send_msg("on60", 8'h90, 8'd60, 8'd100);
    check("on60/v0_note", 64'(voice_note[0]), 64'd60);
    check("on60/v0_vel", 64'(voice_velocity[0]), 64'd100);
    check("on60/upd", 64'(voice_update), 64'h01);
    check("on60/count", 64'(active_count), 64'd1);

    // Nine note-ons: the ninth steals voice 0
    do_reset();
    for (int i = 0; i < 9; i++) send_msg("fill", 8'h90, 8'(60 + i), 8'd90);
    check("steal/stolen", 64'(voice_stolen), 64'd1);
    check("steal/v0_note", 64'(voice_note[0]), 64'd68);
    check("steal/upd", 64'(voice_update), 64'h01);
    check("steal/count", 64'(active_count), 64'd8);
    @(negedge clock_50_000_000);
    check("steal/pulse_end", 64'(voice_stolen), 64'd0);

    // Note-on then velocity-0 note-off, then a redundant note-off
    do_reset();
    send_msg("on", 8'h90, 8'd60, 8'd100);
    send_msg("off0", 8'h90, 8'd60, 8'd0);
    check("off0/gate", 64'(voice_gate), 64'd0);
    check("off0/note", 64'(voice_note[0]), 64'd60);
    check("off0/upd", 64'(voice_update), 64'h01);
    send_msg("off_again", 8'h80, 8'd60, 8'd0);
    check("off_again/upd", 64'(voice_update), 64'h00);

    // All-notes-off on channel 0, then a filtered channel-1 note-on
    do_reset();
    for (int i = 0; i < 4; i++) send_msg("gate4", 8'h90, 8'(60 + i), 8'd70);
    send_msg("anf", 8'hB0, 8'd123, 8'd0);
    check("anf/gate", 64'(voice_gate), 64'd0);
    check("anf/upd", 64'(voice_update), 64'h0F);
    check("anf/count", 64'(active_count), 64'd0);
    send_msg("filt", 8'h91, 8'd50, 8'd60);
    check("filt/upd", 64'(voice_update), 64'd0);

    // Three consecutive valid cycles: only the first is taken
    check("burst/ready", 64'(msg_ready), 64'd1);
    msg_status = 8'h90; msg_data1 = 8'd70; msg_data2 = 8'd11; msg_valid = 1'b1;
    @(posedge clock_50_000_000); #1;
    msg_data1 = 8'd71; msg_data2 = 8'd22;
    @(posedge clock_50_000_000); #1;
    msg_data1 = 8'd72; msg_data2 = 8'd33;
    @(posedge clock_50_000_000); #1;
    msg_valid = 1'b0;
    model_apply(8'h90, 8'd70, 8'd11, eu, es);
    @(negedge clock_50_000_000);
    check("burst/update", 64'(voice_update), 64'(eu));
    check("burst/count", 64'(active_count), 64'd1);
    check_voices("burst");
    @(negedge clock_50_000_000);
    check("burst/no_more_upd", 64'(voice_update), 64'd0);
    check("burst/count2", 64'(active_count), 64'd1);

    // Reset asserted while the FSM is in SEARCH
    msg_status = 8'h90; msg_data1 = 8'd40; msg_data2 = 8'd50; msg_valid = 1'b1;
    @(posedge clock_50_000_000); #1;
    msg_valid = 1'b0;
    @(negedge clock_50_000_000);
    reset = 1'b1;
    #1;
    check("rst_mid/ready", 64'(msg_ready), 64'd1);
    @(negedge clock_50_000_000);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock_50_000_000);
      check("rst_mid/upd", 64'(voice_update), 64'd0);
      check("rst_mid/ready_after", 64'(msg_ready), 64'd1);
    end
    check_voices("rst_mid");

`ifdef SUSTAIN_PEDAL_EN
    // Sustain holds a released note until the pedal is lifted
    send_msg("sus_on", 8'hB0, 8'd64, 8'd127);
    send_msg("sus_note", 8'h90, 8'd60, 8'd100);
    send_msg("sus_off", 8'h80, 8'd60, 8'd0);
    check("sus_off/gate", 64'(voice_gate[0]), 64'd1);
    check("sus_off/upd", 64'(voice_update), 64'd0);
    send_msg("sus_lift", 8'hB0, 8'd64, 8'd0);
    check("sus_lift/gate", 64'(voice_gate[0]), 64'd0);
    check("sus_lift/upd", 64'(voice_update), 64'h01);
`endif

    // Random traffic against the model
    do_reset();
    for (int n = 0; n < 300; n++) begin
      int          k  = int'($urandom_range(0, 9));
      logic [3:0]  ch = 4'($urandom_range(0, 2));
      logic [7:0]  nt = 8'(60 + $urandom_range(0, 11));
      logic [7:0]  st, d1, d2;
      d1 = nt;
      d2 = 8'($urandom_range(1, 127));
      if (k <= 3)      st = {4'h9, ch};
      else if (k == 4) begin st = {4'h9, ch}; d2 = 8'd0; end
      else if (k <= 6) st = {4'h8, ch};
      else if (k == 7) begin st = {4'hB, ch}; d1 = 8'd123; end
      else if (k == 8) begin st = {4'hB, ch}; d1 = 8'd64; d2 = 8'($urandom_range(0, 127)); end
      else             st = {4'hA, ch};
      send_msg("rand", st, d1, d2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
